// File: rtl/dest_drain_counter_pkg.sv
// Shared definitions for the destination drain counter.
//   - Default widths for the destination FIFO word and the per-destination counter.
//   - FSM state encoding and the state transition function.
package dest_drain_counter_pkg;

    localparam int WORD_W_DEF = 8;
    localparam int CNT_W_DEF  = 5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_FLUSH  = 2'd2
    } state_e;

    // FLUSH always lasts exactly one cycle. It gives the word popped in the
    // last ACTIVE cycle time to arrive and be captured before the drain
    // reports itself idle.
    function automatic state_e next_state(input state_e cur, input logic enable);
        state_e nxt;
        case (cur)
            ST_IDLE:   nxt = enable ? ST_ACTIVE : ST_IDLE;
            ST_ACTIVE: nxt = enable ? ST_ACTIVE : ST_FLUSH;
            ST_FLUSH:  nxt = ST_IDLE;
            default:   nxt = ST_IDLE;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/dest_drain_counter_if.sv
// Interface bundling the FIFO-side and bench-side signals of dest_drain_counter.
//   slave  : the drain block. It samples the FIFO flags, data, pause and read
//            requests, and drives the pops, output stream and counter response.
//   master : the environment (the FIFOs plus the checker) that drives the block.
interface dest_drain_counter_if
    import dest_drain_counter_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
);
    logic              enable;
    logic              d0_empty;
    logic              d1_empty;
    logic [WORD_W-1:0] d0_data;
    logic [WORD_W-1:0] d1_data;
    logic [1:0]        sink_pause;
    logic              req;
    logic              idx;
    logic              pop_d0;
    logic              pop_d1;
    logic [1:0]        out_valid;
    logic [WORD_W-1:0] out_data_0;
    logic [WORD_W-1:0] out_data_1;
    logic              cnt_valid;
    logic [CNT_W-1:0]  cnt_data;
    logic              idle;

    modport slave (
        input  enable, d0_empty, d1_empty, d0_data, d1_data, sink_pause, req, idx,
        output pop_d0, pop_d1, out_valid, out_data_0, out_data_1, cnt_valid, cnt_data, idle
    );

    modport master (
        output enable, d0_empty, d1_empty, d0_data, d1_data, sink_pause, req, idx,
        input  pop_d0, pop_d1, out_valid, out_data_0, out_data_1, cnt_valid, cnt_data, idle
    );
endinterface

// File: rtl/dest_drain_counter_lane.sv
// dest_lane: one destination's pop gate, capture register and word counter.
// Ports:
//   clk, reset_L : clock and synchronous active-low reset
//   active       : FSM is in ACTIVE (pops allowed)
//   empty, pause : FIFO empty flag and sink back-pressure for this lane
//   data         : FIFO read data, valid the cycle after a pop
//   pop          : pop strobe (combinational from registered state and inputs)
//   out_valid    : a freshly popped word was captured at the last edge
//   out_data     : last captured word
//   cnt          : words captured since reset, modulo 2^CNT_W
module dest_lane #(
    parameter int WORD_W = 8,
    parameter int CNT_W  = 5
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic              active,
    input  logic              empty,
    input  logic              pause,
    input  logic [WORD_W-1:0] data,
    output logic              pop,
    output logic              out_valid,
    output logic [WORD_W-1:0] out_data,
    output logic [CNT_W-1:0]  cnt
);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic              pop_s;
    logic              pop_r;
    logic              out_valid_r;
    logic [WORD_W-1:0] out_data_r;
    logic [CNT_W-1:0]  cnt_r;

    assign pop_s = active & ~empty & ~pause;

    // pop_r marks a word in flight. The word is on 'data' the cycle after the
    // pop, so it is captured one edge later. That lets the FLUSH cycle pick up
    // the last word popped in ACTIVE. Reset drops any word in flight.
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            pop_r       <= 1'b0;
            out_valid_r <= 1'b0;
            out_data_r  <= {WORD_W{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
        end else begin
            pop_r       <= pop_s;
            out_valid_r <= pop_r;
            if (pop_r) begin
                out_data_r <= data;
                cnt_r      <= cnt_r + CNT_ONE;
            end else begin
                out_data_r <= out_data_r;
                cnt_r      <= cnt_r;
            end
        end
    end

    assign pop       = pop_s;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign cnt       = cnt_r;
endmodule

// File: rtl/dest_drain_counter.sv
// dest_drain_counter: drains destination FIFOs D0/D1 and re-presents the popped
// words as a valid-qualified stream. It also counts the words per destination;
// the counts are read back through a req/idx handshake.
// Ports:
//   clk     : single clock, rising edge
//   reset_L : synchronous reset, active low
//   bus     : dest_drain_counter_if slave (FIFO flags/data, pause, enable,
//             req/idx in; pops, out_valid/out_data_*, cnt_valid/cnt_data, idle out)
module dest_drain_counter
    import dest_drain_counter_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 reset_L,
    dest_drain_counter_if.slave  bus
);
    state_e            state_r;
    logic              idle_r;
    logic              cnt_valid_r;
    logic [CNT_W-1:0]  cnt_data_r;
    logic              active_s;
    logic              ov0_s;
    logic              ov1_s;
    logic [CNT_W-1:0]  cnt0_s;
    logic [CNT_W-1:0]  cnt1_s;

    assign active_s = (state_r == ST_ACTIVE);

    dest_lane #(.WORD_W(WORD_W), .CNT_W(CNT_W)) u_lane0 (
        .clk       (clk),
        .reset_L   (reset_L),
        .active    (active_s),
        .empty     (bus.d0_empty),
        .pause     (bus.sink_pause[0]),
        .data      (bus.d0_data),
        .pop       (bus.pop_d0),
        .out_valid (ov0_s),
        .out_data  (bus.out_data_0),
        .cnt       (cnt0_s)
    );

    dest_lane #(.WORD_W(WORD_W), .CNT_W(CNT_W)) u_lane1 (
        .clk       (clk),
        .reset_L   (reset_L),
        .active    (active_s),
        .empty     (bus.d1_empty),
        .pause     (bus.sink_pause[1]),
        .data      (bus.d1_data),
        .pop       (bus.pop_d1),
        .out_valid (ov1_s),
        .out_data  (bus.out_data_1),
        .cnt       (cnt1_s)
    );

    // The FSM updates idle together with the state. The counter read path
    // samples the counters before any capture at the same edge, so a
    // colliding read returns the pre-increment value.
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            state_r     <= ST_IDLE;
            idle_r      <= 1'b1;
            cnt_valid_r <= 1'b0;
            cnt_data_r  <= {CNT_W{1'b0}};
        end else begin
            state_r     <= next_state(state_r, bus.enable);
            idle_r      <= (next_state(state_r, bus.enable) == ST_IDLE);
            cnt_valid_r <= bus.req;
            if (bus.req) begin
                cnt_data_r <= bus.idx ? cnt1_s : cnt0_s;
            end else begin
                cnt_data_r <= cnt_data_r;
            end
        end
    end

    assign bus.out_valid = {ov1_s, ov0_s};
    assign bus.cnt_valid = cnt_valid_r;
    assign bus.cnt_data  = cnt_data_r;
    assign bus.idle      = idle_r;
endmodule
